// File: rtl/demux4_buffered.sv
// demux4_buffered: steers one valid/ready input word per cycle into a
// one-entry holding slot on one of four valid/ready output channels, and
// keeps a saturating per-channel count of the words routed there.

// One output channel: slot valid flag, held word and saturating count.
module demux4_slot #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_i,     // accepted word is addressed here
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   ready_i,    // consumer takes the word
  output logic                   slot_rdy_o, // slot can take a word this edge
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [COUNT_WIDTH-1:0] count_o
);
  logic                   v_q, v_d;
  logic [WIDTH-1:0]       d_q, d_d;
  logic [COUNT_WIDTH-1:0] c_q, c_d;
  logic                   drain;

  // Next state: a fill wins over a drain so a draining slot can be
  // refilled in the same cycle, giving one word per cycle per channel.
  always_comb begin
    drain = v_q && ready_i;
    v_d   = v_q;
    d_d   = d_q;
    c_d   = c_q;
    if (fill_i) begin
      v_d = 1'b1;
      d_d = data_i;
      if (c_q != {COUNT_WIDTH{1'b1}}) c_d = c_q + 1'b1;
    end else if (drain) begin
      v_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
      c_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  end

  assign slot_rdy_o = !v_q || ready_i;
  assign valid_o    = v_q;
  assign data_o     = d_q;
  assign count_o    = c_q;
endmodule

module demux4_buffered #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   address0,
  input  logic                   address1,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data0,
  output logic [WIDTH-1:0]       out_data1,
  output logic [WIDTH-1:0]       out_data2,
  output logic [WIDTH-1:0]       out_data3,
  output logic                   out_valid0,
  output logic                   out_valid1,
  output logic                   out_valid2,
  output logic                   out_valid3,
  input  logic                   out_ready0,
  input  logic                   out_ready1,
  input  logic                   out_ready2,
  input  logic                   out_ready3,
  output logic [COUNT_WIDTH-1:0] count0,
  output logic [COUNT_WIDTH-1:0] count1,
  output logic [COUNT_WIDTH-1:0] count2,
  output logic [COUNT_WIDTH-1:0] count3
);
  localparam int NUM_LANES = 4;

  logic [1:0]                                sel;
  logic                                      accept;
  logic [NUM_LANES-1:0]                      fill;
  logic [NUM_LANES-1:0]                      slot_rdy;
  logic [NUM_LANES-1:0]                      ordy;
  logic [NUM_LANES-1:0]                      vld;
  logic [NUM_LANES-1:0][WIDTH-1:0]           data;
  logic [NUM_LANES-1:0][COUNT_WIDTH-1:0]     cnt;

  assign ordy = {out_ready3, out_ready2, out_ready1, out_ready0};

  // Input handshake: ready depends only on the addressed slot, never on
  // in_valid, and is held low while reset is asserted.
  always_comb begin
    sel      = {address1, address0};
    in_ready = 1'b0;
    if (!reset) in_ready = slot_rdy[sel];
    accept   = in_valid && in_ready;
    fill     = '0;
    if (accept) fill[sel] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      demux4_slot #(
        .WIDTH       (WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .fill_i     (fill[g]),
        .data_i     (in_data),
        .ready_i    (ordy[g]),
        .slot_rdy_o (slot_rdy[g]),
        .valid_o    (vld[g]),
        .data_o     (data[g]),
        .count_o    (cnt[g])
      );
    end
  endgenerate

  assign out_data0  = data[0];
  assign out_data1  = data[1];
  assign out_data2  = data[2];
  assign out_data3  = data[3];
  assign out_valid0 = vld[0];
  assign out_valid1 = vld[1];
  assign out_valid2 = vld[2];
  assign out_valid3 = vld[3];
  assign count0     = cnt[0];
  assign count1     = cnt[1];
  assign count2     = cnt[2];
  assign count3     = cnt[3];
endmodule

// File: tb/tb_demux4_buffered.sv
// Directed bench for demux4_buffered: default build plus a COUNT_WIDTH=4
// build for the saturation case.
module tb_demux4_buffered;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic [1:0] addr;
  logic       in_valid, in_valid2;
  logic [3:0] ordy;
  logic       in_ready, in_ready2;
  logic [7:0] od0, od1, od2, od3, xd0, xd1, xd2, xd3;
  logic       ov0, ov1, ov2, ov3, xv0, xv1, xv2, xv3;
  logic [7:0] c0, c1, c2, c3;
  logic [3:0] s0, s1, s2, s3;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux4_buffered #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data),
    .address0(addr[0]), .address1(addr[1]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(od0), .out_data1(od1), .out_data2(od2), .out_data3(od3),
    .out_valid0(ov0), .out_valid1(ov1), .out_valid2(ov2), .out_valid3(ov3),
    .out_ready0(ordy[0]), .out_ready1(ordy[1]),
    .out_ready2(ordy[2]), .out_ready3(ordy[3]),
    .count0(c0), .count1(c1), .count2(c2), .count3(c3)
  );

  demux4_buffered #(.WIDTH(8), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .in_data(in_data),
    .address0(addr[0]), .address1(addr[1]),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data0(xd0), .out_data1(xd1), .out_data2(xd2), .out_data3(xd3),
    .out_valid0(xv0), .out_valid1(xv1), .out_valid2(xv2), .out_valid3(xv3),
    .out_ready0(ordy[0]), .out_ready1(ordy[1]),
    .out_ready2(ordy[2]), .out_ready3(ordy[3]),
    .count0(s0), .count1(s1), .count2(s2), .count3(s3)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; ordy = '0;
    addr = 2'd0; in_data = 8'h00;
    step(); step();
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    reset = 1'b0; #1;
    tests++;
    if ({ov3, ov2, ov1, ov0} !== 4'b0000) begin fails++; $display("FAIL reset_valid: got %b want 0000", {ov3, ov2, ov1, ov0}); end
    tests++;
    if ({od3, od2, od1, od0} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {od3, od2, od1, od0}); end
    tests++;
    if ({c3, c2, c1, c0} !== 32'h0) begin fails++; $display("FAIL reset_count: got %h want 0", {c3, c2, c1, c0}); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill_all();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    ordy = '0;
    for (int ch = 0; ch < 4; ch++) begin
      addr = 2'(ch); in_data = w[ch]; in_valid = 1'b1; #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_in_ready ch%0d: got %b want 1", ch, in_ready); end
      step();
    end
    in_valid = 1'b0;
    tests++;
    if ({ov3, ov2, ov1, ov0} !== 4'b1111) begin fails++; $display("FAIL fill_valid: got %b want 1111", {ov3, ov2, ov1, ov0}); end
    tests++;
    if ({od3, od2, od1, od0} !== 32'h44332211) begin fails++; $display("FAIL fill_data: got %h want 44332211", {od3, od2, od1, od0}); end
    tests++;
    if ({c3, c2, c1, c0} !== 32'h01010101) begin fails++; $display("FAIL fill_count: got %h want 01010101", {c3, c2, c1, c0}); end
  endtask

  task automatic test_stall_release();
    addr = 2'd2; in_data = 8'h55; in_valid = 1'b1; ordy = '0; #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    step();
    tests++;
    if (od2 !== 8'h33 || c2 !== 8'd1 || ov2 !== 1'b1) begin fails++; $display("FAIL stall_hold: got d=%h c=%0d v=%b want d=33 c=1 v=1", od2, c2, ov2); end
    ordy[2] = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; ordy = '0;
    tests++;
    if (od2 !== 8'h55 || ov2 !== 1'b1 || c2 !== 8'd2) begin fails++; $display("FAIL refill: got d=%h v=%b c=%0d want d=55 v=1 c=2", od2, ov2, c2); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; step(); reset = 1'b0;
    ordy = 4'b0010; addr = 2'd1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(k); in_valid = 1'b1; #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready); end
      step();
      tests++;
      if (od1 !== 8'(k) || ov1 !== 1'b1) begin fails++; $display("FAIL stream_data k=%0d: got d=%h v=%b want d=%h v=1", k, od1, ov1, 8'(k)); end
    end
    in_valid = 1'b0;
    tests++;
    if (c1 !== 8'd8) begin fails++; $display("FAIL stream_count: got %0d want 8", c1); end
    step();
    tests++;
    if (ov1 !== 1'b0 || od1 !== 8'h08) begin fails++; $display("FAIL stream_drain: got v=%b d=%h want v=0 d=08", ov1, od1); end
    ordy = '0;
  endtask

  task automatic test_no_hol();
    addr = 2'd0; in_data = 8'hC3; in_valid = 1'b1; ordy = '0;
    step();
    addr = 2'd3; in_data = 8'hA0; #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL nohol_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++;
    if (od0 !== 8'hC3 || ov0 !== 1'b1 || od3 !== 8'hA0 || ov3 !== 1'b1) begin
      fails++; $display("FAIL nohol_data: got d0=%h v0=%b d3=%h v3=%b want C3 1 A0 1", od0, ov0, od3, ov3);
    end
    ordy = 4'b1001;
    step();
    ordy = '0;
    tests++;
    if (ov0 !== 1'b0 || ov3 !== 1'b0 || od0 !== 8'hC3 || od3 !== 8'hA0) begin
      fails++; $display("FAIL drain_hold: got v0=%b v3=%b d0=%h d3=%h want 0 0 C3 A0", ov0, ov3, od0, od3);
    end
  endtask

  task automatic test_saturate();
    int exp;
    addr = 2'd0; ordy = 4'b0001; in_valid2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_data = 8'(k);
      step();
      exp = (k > 15) ? 15 : k;
      tests++;
      if (s0 !== 4'(exp)) begin fails++; $display("FAIL sat_count k=%0d: got %0d want %0d", k, s0, exp); end
    end
    in_valid2 = 1'b0; ordy = '0;
  endtask

  task automatic test_reset_mid();
    ordy = '0; in_valid = 1'b1;
    addr = 2'd1; in_data = 8'h61; step();
    addr = 2'd2; in_data = 8'h62; step();
    addr = 2'd0; in_data = 8'h99; reset = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    step();
    reset = 1'b0; in_valid = 1'b0;
    tests++;
    if ({ov3, ov2, ov1, ov0} !== 4'b0000) begin fails++; $display("FAIL rst_mid_valid: got %b want 0000", {ov3, ov2, ov1, ov0}); end
    tests++;
    if ({od3, od2, od1, od0} !== 32'h0) begin fails++; $display("FAIL rst_mid_data: got %h want 0", {od3, od2, od1, od0}); end
    tests++;
    if ({c3, c2, c1, c0} !== 32'h0) begin fails++; $display("FAIL rst_mid_count: got %h want 0", {c3, c2, c1, c0}); end
  endtask

  initial begin
    test_reset();
    test_fill_all();
    test_stall_release();
    test_back_to_back();
    test_no_hol();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux4_buffered.md
Name: demux4_buffered

Overview:
Four-way registered demultiplexer, the routing counterpart to the 4:1 multiplexer in the same datapath. Accepts one WIDTH-bit word per cycle on a valid/ready input port. Steers each word, by a 2-bit address, into a one-entry holding slot on one of four valid/ready output channels. Keeps a saturating per-channel count of words routed.

Parameters:
WIDTH, 8, data word width in bits
COUNT_WIDTH, 8, width of each per-channel routed-word counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  word to route
address0  input  1  channel select, LSB
address1  input  1  channel select, MSB; channel = {address1, address0}
in_valid  input  1  in_data and address are valid this cycle
in_ready  output  1  demux can accept this cycle
out_data0..out_data3  output  WIDTH each  held word for channel 0..3
out_valid0..out_valid3  output  1 each  channel slot holds a word
out_ready0..out_ready3  input  1 each  channel consumer takes the word this cycle
count0..count3  output  COUNT_WIDTH each  words accepted into channel 0..3, saturating

Behaviour:
- Channel a = {address1, address0}: 0 to 3, address0 is the LSB.
- Each channel i has:
  - slot valid flag v_i, driven on out_valid_i
  - data register d_i, driven on out_data_i
  - counter c_i, driven on count_i
- All outputs are registered except in_ready.
- Reset (reset=1 at a rising edge):
  - all v_i <= 0, d_i <= 0, c_i <= 0
  - any buffered words are discarded, including when reset asserts mid-stream
  - in_ready is forced 0 combinationally while reset is high; no accept occurs in a reset cycle.
- in_ready = !reset && (!v_a || out_ready_a).
  - Combinational from address and the addressed out_ready.
  - Does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - d_a <= in_data, v_a <= 1
  - c_a <= c_a + 1 unless c_a is all ones; then it holds (saturates, never wraps)
  - Latency: the word appears on out_data_a / out_valid_a the cycle after accept.
- Drain: out_valid_i && out_ready_i at an edge consumes the slot.
  - If channel i is not being filled that cycle, v_i <= 0 and d_i holds its last value.
- Simultaneous drain and fill on the same channel:
  - v_a stays 1, d_a takes the new word, c_a increments.
  - This gives one word per cycle sustained on a single channel.
- Drains on other channels proceed independently in the same cycle as an accept; up to 4 drains plus 1 fill per cycle.
- Stall: out_valid_i=1 with out_ready_i=0 holds d_i and v_i unchanged indefinitely.
  - in_ready is 0 only while the addressed channel is full and not draining.
  - Words for other channels are still accepted (no head-of-line blocking inside the demux).
- Source rule: while in_valid=1 and in_ready=0, the source holds in_data and the address stable. in_valid may drop without a transfer.
- in_valid=0: no state change except drains.
- out_ready_i while v_i=0 has no effect.
- Address bits are sampled only at accept. Changing them between words is legal; X on the address with in_valid=0 is ignored.
- Counter width rule: c_i is COUNT_WIDTH bits unsigned. Saturation value is 2^COUNT_WIDTH-1 (255 at default).

Test Plan:
1. Reset sequence, then route 0x11, 0x22, 0x33, 0x44 to channels 0..3 on consecutive cycles with all out_ready=0 -> in_ready=1 each cycle; next cycle out_valid0..3=1, out_data=0x11/0x22/0x33/0x44, count0..3=1.
2. With all four slots full and out_ready=0, present 0x55 to channel 2 -> in_ready=0, no change. Raise out_ready2 -> accept that edge; out_data2=0x55, out_valid2 stays 1, count2=2.
3. Stream 0x01..0x08 to channel 1 with out_ready1=1 -> one accept per cycle; out_data1 shows 0x01..0x08 one cycle delayed; count1=8; out_valid1 drops the cycle after in_valid drops.
4. Channel 0 full and stalled; send 0xA0 to channel 3 -> accepted immediately; out_data0 stays unchanged, out_data3=0xA0 next cycle.
5. COUNT_WIDTH=4: route 20 words to channel 0 with out_ready0=1 -> count0 reaches 15 and holds 15, never wraps to 0.
6. Assert reset for one cycle with slots 1 and 2 full and in_valid=1 -> in_ready=0 during reset; afterwards all out_valid=0, out_data=0, counts=0, and no word is accepted in the reset cycle.
